// File: rtl/core_readout_ctrl_pkg.sv
// Shared types and constants for the trigger-driven core readout controller.
// Word layout: [23:22] type, [21:17] trigger id, [16] error, [15:0] payload.
package core_readout_ctrl_pkg;

  localparam int TRIG_DEPTH_DEF = 4;
  localparam int TOK_SETTLE_DEF = 2;
  localparam int DATA_LAT_DEF   = 1;
  localparam int MAX_HITS_DEF   = 64;

  localparam int ID_W     = 5;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 7;
  localparam int TYPE_W   = 2;
  localparam int WORD_W   = 24;
  localparam int TYPE_LSB = 22;
  localparam int ID_LSB   = 17;
  localparam int ERR_BIT  = 16;
  localparam int PAY_LSB  = 0;

  typedef enum logic [1:0] {
    WT_NONE = 2'b00,
    WT_HDR  = 2'b01,
    WT_HIT  = 2'b10,
    WT_TRL  = 2'b11
  } word_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SETTLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_PUSH,
    S_TRL
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input word_type_e        t,
    input logic [ID_W-1:0]   id,
    input logic              err,
    input logic [DATA_W-1:0] pay
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[TYPE_LSB +: TYPE_W] = t;
    w[ID_LSB +: ID_W]     = id;
    w[ERR_BIT]            = err;
    w[PAY_LSB +: DATA_W]  = pay;
    return w;
  endfunction

endpackage

// File: rtl/core_readout_ctrl_if.sv
// Trigger, token-chain and output-stream signals of the readout controller.
// master is the controller side, slave the environment side.
interface core_readout_ctrl_if;
  import core_readout_ctrl_pkg::*;

  logic              trig_valid;
  logic [ID_W-1:0]   trig_id_in;
  logic              tok_out;
  logic [DATA_W-1:0] data_to_core;
  logic [ID_W-1:0]   trig_id_req;
  logic              tok_in;
  logic              read;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              trig_full;
  logic              trig_ovf;

  modport master (
    input  trig_valid, trig_id_in, tok_out,
    input  data_to_core, data_ready,
    output trig_id_req, tok_in, read,
    output data_out, data_valid,
    output trig_full, trig_ovf
  );

  modport slave (
    output trig_valid, trig_id_in, tok_out,
    output data_to_core, data_ready,
    input  trig_id_req, tok_in, read,
    input  data_out, data_valid,
    input  trig_full, trig_ovf
  );

endinterface

// File: rtl/core_readout_ctrl_trig_fifo.sv
// Pending-trigger FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle, otherwise it is dropped and flagged.
module readout_trig_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_readout_ctrl.sv
// Per-trigger readout: header, token-driven hit reads, trailer.
// Output words are built combinationally from registers held during stalls.
module core_readout_ctrl
  import core_readout_ctrl_pkg::*;
#(
  parameter int TRIG_DEPTH = TRIG_DEPTH_DEF,
  parameter int TOK_SETTLE = TOK_SETTLE_DEF,
  parameter int DATA_LAT   = DATA_LAT_DEF,
  parameter int MAX_HITS   = MAX_HITS_DEF
) (
  input logic                 clk,
  input logic                 rst,
  core_readout_ctrl_if.master bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(TOK_SETTLE - 1);
  localparam logic [7:0] LAT_LAST    = 8'(DATA_LAT - 1);
  localparam logic [CNT_W-1:0] HIT_MAX = CNT_W'(MAX_HITS);

  state_e            state;
  state_e            state_nxt;
  logic [ID_W-1:0]   id_q;
  logic              tok_q;
  logic              err_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  hit_cnt;
  logic [DATA_W-1:0] hold_q;
  logic [7:0]        tmr;

  logic [ID_W-1:0]   fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_ovf;
  logic              fifo_pop;

  logic              valid;
  logic              rd;
  word_type_e        wtype;
  logic [DATA_W-1:0] payload;

  readout_trig_fifo #(
    .DEPTH (TRIG_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.trig_valid),
    .pop   (fifo_pop),
    .din   (bus.trig_id_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    rd        = 1'b0;
    fifo_pop  = 1'b0;
    wtype     = WT_NONE;
    payload   = '0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_HDR;
      end
      S_HDR: begin
        valid = 1'b1;
        wtype = WT_HDR;
        if (bus.data_ready) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr == SETTLE_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (bus.tok_out && hit_cnt < HIT_MAX) state_nxt = S_READ;
        else                                  state_nxt = S_TRL;
      end
      S_READ: begin
        rd        = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tmr == LAT_LAST) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        valid   = 1'b1;
        wtype   = WT_HIT;
        payload = hold_q;
        if (bus.data_ready) state_nxt = S_SETTLE;
      end
      S_TRL: begin
        valid   = 1'b1;
        wtype   = WT_TRL;
        payload = {{(DATA_W-CNT_W){1'b0}}, hit_cnt};
        if (bus.data_ready) begin
          fifo_pop  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // err_q only rises on the CHECK->TRL edge, so header/hit words carry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      tok_q   <= 1'b0;
      err_q   <= 1'b0;
      hit_cnt <= '0;
      hold_q  <= '0;
      tmr     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) id_q <= fifo_head;
        end
        S_HDR: begin
          if (bus.data_ready) begin
            tok_q <= 1'b1;
            tmr   <= '0;
          end
        end
        S_SETTLE: tmr <= tmr + 8'd1;
        S_CHECK: begin
          err_q <= bus.tok_out & (hit_cnt >= HIT_MAX);
        end
        S_READ: tmr <= '0;
        S_WAIT: begin
          tmr <= tmr + 8'd1;
          if (tmr == LAT_LAST) hold_q <= bus.data_to_core;
        end
        S_PUSH: begin
          if (bus.data_ready) begin
            hit_cnt <= hit_cnt + 1'b1;
            tmr     <= '0;
          end
        end
        S_TRL: begin
          if (bus.data_ready) begin
            hit_cnt <= '0;
            err_q   <= 1'b0;
            tok_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (fifo_ovf) ovf_q <= 1'b1;
  end

  assign bus.trig_id_req = id_q;
  assign bus.tok_in      = tok_q;
  assign bus.read        = rd;
  assign bus.data_valid  = valid;
  assign bus.data_out    = valid ? pack_word(wtype, id_q, err_q, payload) : '0;
  assign bus.trig_full   = fifo_full;
  assign bus.trig_ovf    = ovf_q;

endmodule
